// File: rtl/pq_reg_server.sv
// pq_reg_server: sorted-register priority queue, server end of the pq_rd_if interface.
//
// Holds up to DEPTH key/value entries kept in ascending key order in a register
// array, and always presents the minimum entry on kvo_o. Each accepted request
// takes two cycles: IDLE samples it, EXEC commits it, so busy_o is high for
// exactly one cycle per operation.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_ni     synchronous reset, active-low
//   kvi_i      key/value to insert, key in the MSBs
//   replace_i  insert request, sampled only while idle
//   deq_i      remove-minimum request, sampled only while idle
//   kvo_o      current minimum entry, 0 when empty
//   full_o     occupancy equals DEPTH
//   empty_o    occupancy is zero
//   busy_o     operation in progress, requests are dropped
//   count_o    occupancy
module pq_reg_server #(
    parameter int DEPTH = 8,
    parameter int KW    = 8,
    parameter int VW    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [KW+VW-1:0]             kvi_i,
    input  logic                         replace_i,
    input  logic                         deq_i,
    output logic [KW+VW-1:0]             kvo_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int W  = KW + VW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    localparam logic [1:0] OP_INS  = 2'd0;
    localparam logic [1:0] OP_REM  = 2'd1;
    localparam logic [1:0] OP_RTOP = 2'd2;

    logic [0:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  kv_q, kv_d;
    logic [W-1:0]  kvo_q, kvo_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  slot_q [DEPTH];
    logic [W-1:0]  slot_d [DEPTH];

    // Removal-shifted view of the array; replace-top reuses it as the base
    // into which the new entry is inserted, so both happen in one EXEC cycle.
    logic [W-1:0]  src [DEPTH];
    logic [CW-1:0] src_cnt;
    logic [DEPTH-1:0] le;
    logic [W-1:0]  ins [DEPTH];

    always_comb begin
        src     = slot_q;
        src_cnt = count_q;
        if (op_q != OP_INS) begin
            for (int i = 0; i < DEPTH - 1; i++) src[i] = slot_q[i+1];
            src[DEPTH-1] = '0;
            src_cnt      = count_q - CW'(1);
        end
    end

    // le marks occupied slots whose key is <= the new key. Because the array
    // is sorted this is a prefix, and using <= puts equal keys after existing
    // ones, which keeps FIFO order among ties.
    always_comb begin
        le = '0;
        for (int i = 0; i < DEPTH; i++)
            le[i] = (i < int'(src_cnt)) && (src[i][W-1:VW] <= kv_q[W-1:VW]);
    end

    always_comb begin
        ins[0] = le[0] ? src[0] : kv_q;
        for (int i = 1; i < DEPTH; i++)
            ins[i] = le[i] ? src[i] : (le[i-1] ? kv_q : src[i-1]);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        kv_d    = kv_q;
        slot_d  = slot_q;
        count_d = count_q;
        if (state_q == IDLE) begin
            kv_d = kvi_i;
            // replace+deq on an empty queue falls through to plain insert.
            if (replace_i && deq_i && count_q != '0) begin
                op_d    = OP_RTOP;
                state_d = EXEC;
            end else if (replace_i && count_q != FULL_CNT) begin
                op_d    = OP_INS;
                state_d = EXEC;
            end else if (deq_i && !replace_i && count_q != '0) begin
                op_d    = OP_REM;
                state_d = EXEC;
            end
        end else begin
            state_d = IDLE;
            if (op_q == OP_REM) slot_d = src;
            else                slot_d = ins;
            count_d = (op_q == OP_INS) ? count_q + CW'(1) :
                      (op_q == OP_REM) ? count_q - CW'(1) : count_q;
        end
        kvo_d = (count_d == '0) ? '0 : slot_d[0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_INS;
            kv_q    <= '0;
            kvo_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            kv_q    <= kv_d;
            kvo_q   <= kvo_d;
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

    assign kvo_o   = kvo_q;
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign busy_o  = (state_q == EXEC);
endmodule
